// File: rtl/computie_bus_initiator_if.sv
// Request/response and multiplexed-bus signal bundle for the computie bus initiator.
// The master modport is the initiator's view; the slave modport is the view of the environment or target.
interface computie_bus_initiator_if #(
  parameter int BITWIDTH = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [BITWIDTH-1:0] req_addr;
  logic [BITWIDTH-1:0] req_wdata;

  logic                resp_valid;
  logic [BITWIDTH-1:0] resp_rdata;
  logic                resp_error;

  logic                cb_addr_strobe;
  logic                cb_data_strobe;
  logic                cb_read_write;
  logic                cb_data_ack;
  logic [BITWIDTH-1:0] cb_ad_out;
  logic [BITWIDTH-1:0] cb_ad_in;
  logic                cb_ad_oe;

  logic                send_receive;
  logic                data_dir;
  logic                addr_oe;
  logic                data_oe;
  logic                al_oe;
  logic                al_le;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  cb_data_ack, cb_ad_in,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output cb_addr_strobe, cb_data_strobe, cb_read_write,
    output cb_ad_out, cb_ad_oe,
    output send_receive, data_dir, addr_oe, data_oe, al_oe, al_le
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output cb_data_ack, cb_ad_in,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  cb_addr_strobe, cb_data_strobe, cb_read_write,
    input  cb_ad_out, cb_ad_oe,
    input  send_receive, data_dir, addr_oe, data_oe, al_oe, al_le
  );
endinterface

// File: rtl/computie_bus_initiator.sv
// Computie bus master: one request at a time through IDLE/ADDR/DATA/WAIT_ACK/END, all state on negedge cb_clk.
// Define COMPUTIE_BUS_TIMEOUT_EN to enable the WAIT_ACK timeout (TIMEOUT parameter) and resp_error reporting.
module computie_bus_initiator #(
  parameter int BITWIDTH = 32
`ifdef COMPUTIE_BUS_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic                      cb_clk,
  input  logic                      cb_reset,
  computie_bus_initiator_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WAIT_ACK,
    S_END
  } state_t;

  state_t              r_state,          w_state_next;
  logic                r_write,          w_write_next;
  logic [BITWIDTH-1:0] r_wdata,          w_wdata_next;

  logic                r_addr_strobe,    w_addr_strobe_next;
  logic                r_data_strobe,    w_data_strobe_next;
  logic                r_read_write,     w_read_write_next;
  logic [BITWIDTH-1:0] r_ad_out,         w_ad_out_next;
  logic                r_ad_oe,          w_ad_oe_next;
  logic                r_send_receive,   w_send_receive_next;
  logic                r_data_dir,       w_data_dir_next;
  logic                r_addr_oe,        w_addr_oe_next;
  logic                r_data_oe,        w_data_oe_next;
  logic                r_al_le,          w_al_le_next;
  logic                r_resp_valid,     w_resp_valid_next;
  logic                r_resp_error,     w_resp_error_next;
  logic [BITWIDTH-1:0] r_resp_rdata,     w_resp_rdata_next;

  logic                w_timeout;

`ifdef COMPUTIE_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  // Counter saturates at the expiry value; the FSM leaves WAIT_ACK on that same edge.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_cnt_next = r_cnt;
    if (r_state == S_DATA) begin
      w_cnt_next = '0;
    end else if ((r_state == S_WAIT_ACK) && bus.cb_data_ack && !w_timeout) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(negedge cb_clk or posedge cb_reset) begin
    if (cb_reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next        = r_state;
    w_write_next        = r_write;
    w_wdata_next        = r_wdata;
    w_addr_strobe_next  = r_addr_strobe;
    w_data_strobe_next  = r_data_strobe;
    w_read_write_next   = r_read_write;
    w_ad_out_next       = r_ad_out;
    w_ad_oe_next        = r_ad_oe;
    w_send_receive_next = r_send_receive;
    w_data_dir_next     = r_data_dir;
    w_addr_oe_next      = r_addr_oe;
    w_data_oe_next      = r_data_oe;
    w_al_le_next        = r_al_le;
    w_resp_valid_next   = 1'b0;
    w_resp_error_next   = r_resp_error;
    w_resp_rdata_next   = r_resp_rdata;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_write_next        = bus.req_write;
          w_wdata_next        = bus.req_wdata;
          w_ad_out_next       = bus.req_addr;
          w_ad_oe_next        = 1'b1;
          w_send_receive_next = 1'b1;
          w_addr_oe_next      = 1'b0;
          w_al_le_next        = 1'b1;
          w_read_write_next   = ~bus.req_write;
          w_state_next        = S_ADDR;
        end
      end

      // Address has been on the bus for a full cycle before the strobe falls.
      S_ADDR: begin
        w_addr_strobe_next = 1'b0;
        w_al_le_next       = 1'b0;
        w_state_next       = S_DATA;
      end

      S_DATA: begin
        w_addr_oe_next     = 1'b1;
        w_data_oe_next     = 1'b0;
        w_data_strobe_next = 1'b0;
        if (r_write) begin
          w_ad_out_next   = r_wdata;
          w_data_dir_next = 1'b1;
        end else begin
          w_ad_oe_next        = 1'b0;
          w_send_receive_next = 1'b0;
          w_data_dir_next     = 1'b0;
        end
        w_state_next = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (!bus.cb_data_ack) begin
          if (!r_write) begin
            w_resp_rdata_next = bus.cb_ad_in;
          end
          w_addr_strobe_next = 1'b1;
          w_data_strobe_next = 1'b1;
          w_resp_valid_next  = 1'b1;
          w_resp_error_next  = 1'b0;
          w_state_next       = S_END;
        end else if (w_timeout) begin
          w_addr_strobe_next = 1'b1;
          w_data_strobe_next = 1'b1;
          w_resp_valid_next  = 1'b1;
          w_resp_error_next  = 1'b1;
          w_state_next       = S_END;
        end
      end

      // Bus turnaround: release every driver before the next request may start.
      S_END: begin
        w_ad_oe_next        = 1'b0;
        w_data_oe_next      = 1'b1;
        w_addr_oe_next      = 1'b1;
        w_send_receive_next = 1'b0;
        w_data_dir_next     = 1'b0;
        w_state_next        = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(negedge cb_clk or posedge cb_reset) begin
    if (cb_reset) begin
      r_state        <= S_IDLE;
      r_write        <= 1'b0;
      r_wdata        <= '0;
      r_addr_strobe  <= 1'b1;
      r_data_strobe  <= 1'b1;
      r_read_write   <= 1'b1;
      r_ad_out       <= '0;
      r_ad_oe        <= 1'b0;
      r_send_receive <= 1'b0;
      r_data_dir     <= 1'b0;
      r_addr_oe      <= 1'b1;
      r_data_oe      <= 1'b1;
      r_al_le        <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_error   <= 1'b0;
      r_resp_rdata   <= '0;
    end else begin
      r_state        <= w_state_next;
      r_write        <= w_write_next;
      r_wdata        <= w_wdata_next;
      r_addr_strobe  <= w_addr_strobe_next;
      r_data_strobe  <= w_data_strobe_next;
      r_read_write   <= w_read_write_next;
      r_ad_out       <= w_ad_out_next;
      r_ad_oe        <= w_ad_oe_next;
      r_send_receive <= w_send_receive_next;
      r_data_dir     <= w_data_dir_next;
      r_addr_oe      <= w_addr_oe_next;
      r_data_oe      <= w_data_oe_next;
      r_al_le        <= w_al_le_next;
      r_resp_valid   <= w_resp_valid_next;
      r_resp_error   <= w_resp_error_next;
      r_resp_rdata   <= w_resp_rdata_next;
    end
  end

  assign bus.req_ready      = (r_state == S_IDLE);
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_error     = r_resp_error;
  assign bus.resp_rdata     = r_resp_rdata;
  assign bus.cb_addr_strobe = r_addr_strobe;
  assign bus.cb_data_strobe = r_data_strobe;
  assign bus.cb_read_write  = r_read_write;
  assign bus.cb_ad_out      = r_ad_out;
  assign bus.cb_ad_oe       = r_ad_oe;
  assign bus.send_receive   = r_send_receive;
  assign bus.data_dir       = r_data_dir;
  assign bus.addr_oe        = r_addr_oe;
  assign bus.data_oe        = r_data_oe;
  assign bus.al_le          = r_al_le;
  // The initiator never uses the address latch output.
  assign bus.al_oe          = 1'b1;

endmodule
